// File: rtl/datapath_ctrl.sv
// Instruction sequencer for the register-file/ALU datapath: decodes one instruction,
// then walks fetch/execute/writeback with one enable per phase and a done pulse.
module datapath_ctrl #(
   parameter int DataSize = 32,
   parameter int AddrSize = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DataSize-1:0] inst,
   input  logic                inst_valid,
   output logic                inst_ready,
   input  logic                alu_overflow,
   input  logic                ovf_clear,
   output logic [AddrSize-1:0] read_address1,
   output logic [AddrSize-1:0] read_address2,
   output logic [AddrSize-1:0] write_address,
   output logic                enable_fetch,
   output logic                enable_execute,
   output logic                enable_writeback,
   output logic [4:0]          imm_5bit,
   output logic [14:0]         imm_15bit,
   output logic [19:0]         imm_20bit,
   output logic [1:0]          mux4to1_select,
   output logic                imm_reg_select,
   output logic                mux2to1_select,
   output logic [5:0]          opcode,
   output logic [4:0]          sub_opcode,
   output logic                busy,
   output logic                done,
   output logic                illegal,
   output logic                ovf_sticky
);

   localparam logic [5:0] OP_ALU1 = 6'b100000;
   localparam logic [5:0] OP_ADDI = 6'b101000;
   localparam logic [5:0] OP_ORI  = 6'b101100;
   localparam logic [5:0] OP_XORI = 6'b101011;
   localparam logic [5:0] OP_MOVI = 6'b100010;

   typedef struct packed {
      logic [AddrSize-1:0] ra;
      logic [AddrSize-1:0] rb;
      logic [AddrSize-1:0] rt;
      logic [4:0]          imm5;
      logic [14:0]         imm15;
      logic [19:0]         imm20;
      logic [1:0]          mux4;
      logic                imm_sel;
      logic                mux2;
      logic [5:0]          op;
      logic [4:0]          sub;
      logic                movi;
      logic                bad;
   } dec_t;

   typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, FIN} state_t;

   state_t state, state_nxt;
   dec_t   dec, dec_q;
   logic   legal;
   logic   accept;

   // Fields an instruction does not use stay 0; an illegal word decodes to all zeros.
   always_comb begin
      dec   = '0;
      legal = 1'b1;
      case (inst[30:25])
         OP_ALU1: begin
            dec.sub = inst[4:0];
            dec.ra  = inst[19:15];
            if (inst[4:0] == 5'b01000 || inst[4:0] == 5'b01001 || inst[4:0] == 5'b01011) begin
               dec.imm_sel = 1'b1;
               dec.imm5    = inst[14:10];
            end else begin
               dec.rb = inst[14:10];
            end
         end
         OP_ADDI: begin
            dec.ra      = inst[19:15];
            dec.mux4    = 2'b01;
            dec.imm15   = inst[14:0];
            dec.imm_sel = 1'b1;
         end
         OP_ORI, OP_XORI: begin
            dec.ra      = inst[19:15];
            dec.mux4    = 2'b10;
            dec.imm15   = inst[14:0];
            dec.imm_sel = 1'b1;
         end
         OP_MOVI: begin
            dec.mux4    = 2'b11;
            dec.imm20   = inst[19:0];
            dec.imm_sel = 1'b1;
            dec.mux2    = 1'b1;
            dec.movi    = 1'b1;
         end
         default: legal = 1'b0;
      endcase
      if (inst[31]) legal = 1'b0;
      if (legal) begin
         dec.op = inst[30:25];
         dec.rt = inst[24:20];
      end else begin
         dec     = '0;
         dec.bad = 1'b1;
      end
   end

   assign accept = (state == IDLE) && inst_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         dec_q <= '0;
      end else begin
         state <= state_nxt;
         if (accept) dec_q <= dec;
      end
   end

   always_comb begin
      state_nxt        = state;
      inst_ready       = 1'b0;
      enable_fetch     = 1'b0;
      enable_execute   = 1'b0;
      enable_writeback = 1'b0;
      done             = 1'b0;
      illegal          = 1'b0;
      case (state)
         IDLE: begin
            inst_ready = 1'b1;
            if (inst_valid) state_nxt = dec.bad ? FIN : FETCH;
         end
         FETCH: begin
            enable_fetch = 1'b1;
            state_nxt    = dec_q.movi ? WB : EXEC;
         end
         EXEC: begin
            enable_execute = 1'b1;
            state_nxt      = WB;
         end
         WB: begin
            enable_writeback = 1'b1;
            state_nxt        = FIN;
         end
         FIN: begin
            done      = 1'b1;
            illegal   = dec_q.bad;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Clear wins over a same-cycle overflow; MOVI never touches the ALU flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         ovf_sticky <= 1'b0;
      else if (ovf_clear)
         ovf_sticky <= 1'b0;
      else if (state == WB && !dec_q.movi && alu_overflow)
         ovf_sticky <= 1'b1;
   end

   assign busy           = (state != IDLE);
   assign read_address1  = dec_q.ra;
   assign read_address2  = dec_q.rb;
   assign write_address  = dec_q.rt;
   assign imm_5bit       = dec_q.imm5;
   assign imm_15bit      = dec_q.imm15;
   assign imm_20bit      = dec_q.imm20;
   assign mux4to1_select = dec_q.mux4;
   assign imm_reg_select = dec_q.imm_sel;
   assign mux2to1_select = dec_q.mux2;
   assign opcode         = dec_q.op;
   assign sub_opcode     = dec_q.sub;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Randomized bench for datapath_ctrl against a phase-list reference model.
module tb_datapath_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] inst = '0;
   logic        inst_valid = 1'b0;
   logic        inst_ready;
   logic        alu_overflow = 1'b0;
   logic        ovf_clear = 1'b0;
   logic [4:0]  read_address1, read_address2, write_address;
   logic        enable_fetch, enable_execute, enable_writeback;
   logic [4:0]  imm_5bit;
   logic [14:0] imm_15bit;
   logic [19:0] imm_20bit;
   logic [1:0]  mux4to1_select;
   logic        imm_reg_select, mux2to1_select;
   logic [5:0]  opcode;
   logic [4:0]  sub_opcode;
   logic        busy, done, illegal, ovf_sticky;

   int n_chk  = 0;
   int n_pass = 0;
   logic model_sticky = 1'b0;

   datapath_ctrl #(.DataSize(32), .AddrSize(5)) dut (
      .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .alu_overflow(alu_overflow), .ovf_clear(ovf_clear),
      .read_address1(read_address1), .read_address2(read_address2), .write_address(write_address),
      .enable_fetch(enable_fetch), .enable_execute(enable_execute), .enable_writeback(enable_writeback),
      .imm_5bit(imm_5bit), .imm_15bit(imm_15bit), .imm_20bit(imm_20bit),
      .mux4to1_select(mux4to1_select), .imm_reg_select(imm_reg_select), .mux2to1_select(mux2to1_select),
      .opcode(opcode), .sub_opcode(sub_opcode), .busy(busy), .done(done), .illegal(illegal),
      .ovf_sticky(ovf_sticky)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  ra, rb, rt, imm5, sub;
      logic [14:0] imm15;
      logic [19:0] imm20;
      logic [1:0]  mux4;
      logic        imm_sel, mux2, bad, movi;
      logic [5:0]  op;
   } exp_t;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic exp_t ref_decode(input logic [31:0] w);
      exp_t e;
      logic [5:0] op = w[30:25];
      logic [4:0] s  = w[4:0];
      logic shift_imm = (s == 5'd8) || (s == 5'd9) || (s == 5'd11);
      e = '{default: '0};
      if (w[31] || !(op inside {6'h20, 6'h28, 6'h2C, 6'h2B, 6'h22})) begin
         e.bad = 1'b1;
         return e;
      end
      e.op = op;
      e.rt = w[24:20];
      if (op == 6'h22) begin
         e.movi = 1'b1; e.mux4 = 2'd3; e.imm20 = w[19:0]; e.imm_sel = 1'b1; e.mux2 = 1'b1;
      end else begin
         e.ra = w[19:15];
         if (op == 6'h20) begin
            e.sub = s;
            if (shift_imm) begin e.imm_sel = 1'b1; e.imm5 = w[14:10]; end
            else e.rb = w[14:10];
         end else begin
            e.imm_sel = 1'b1;
            e.imm15   = w[14:0];
            e.mux4    = (op == 6'h28) ? 2'd1 : 2'd2;
         end
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] w = $urandom;
      logic [4:0]  shifts [3] = '{5'd8, 5'd9, 5'd11};
      logic [5:0]  legal [5] = '{6'h20, 6'h28, 6'h2C, 6'h2B, 6'h22};
      int k = $urandom_range(0, 7);
      w[31] = 1'b0;
      case (k)
         0: w[30:25] = 6'h20;
         1: begin w[30:25] = 6'h20; w[4:0] = shifts[$urandom_range(0, 2)]; end
         2: w[30:25] = 6'h28;
         3: w[30:25] = 6'h2C;
         4: w[30:25] = 6'h2B;
         5: w[30:25] = 6'h22;
         6: ;
         default: begin w[30:25] = legal[$urandom_range(0, 4)]; w[31] = 1'b1; end
      endcase
      return w;
   endfunction

   // ovf_mode: 0 random, 1 overflow always high, 2 overflow and clear always high
   task automatic drive_ovf(input int ovf_mode);
      alu_overflow = (ovf_mode != 0) ? 1'b1 : 1'($urandom_range(0, 1));
      ovf_clear    = (ovf_mode == 2) ? 1'b1 : (ovf_mode == 1) ? 1'b0 : ($urandom_range(0, 7) == 0);
   endtask

   task automatic run_inst(input logic [31:0] w, input int ovf_mode);
      exp_t e = ref_decode(w);
      int   ph[$];
      logic [2:0] en_exp;
      if (e.bad) ph = '{4};
      else if (e.movi) ph = '{1, 3, 4};
      else ph = '{1, 2, 3, 4};
      inst = w;
      inst_valid = 1'b1;
      drive_ovf(ovf_mode);
      chk("ready_idle", {busy, inst_ready}, 2'b01);
      chk("sticky", ovf_sticky, model_sticky);
      if (ovf_clear) model_sticky = 1'b0;
      @(posedge clk); #1;
      foreach (ph[i]) begin
         en_exp = (ph[i] == 1) ? 3'b100 : (ph[i] == 2) ? 3'b010 : (ph[i] == 3) ? 3'b001 : 3'b000;
         chk("enables", {enable_fetch, enable_execute, enable_writeback}, en_exp);
         chk("done_ill", {done, illegal}, {ph[i] == 4, ph[i] == 4 && e.bad});
         chk("busy_rdy", {busy, inst_ready}, 2'b10);
         chk("sticky", ovf_sticky, model_sticky);
         chk("addr", {read_address1, read_address2, write_address}, {e.ra, e.rb, e.rt});
         chk("imm", {imm_5bit, imm_15bit, imm_20bit}, {e.imm5, e.imm15, e.imm20});
         chk("sel", {mux4to1_select, imm_reg_select, mux2to1_select}, {e.mux4, e.imm_sel, e.mux2});
         chk("ops", {opcode, sub_opcode}, {e.op, e.sub});
         // inst changes and inst_valid stays high while busy: neither may be re-sampled
         inst = $urandom;
         drive_ovf(ovf_mode);
         if (ovf_clear) model_sticky = 1'b0;
         else if (ph[i] == 3 && !e.movi && alu_overflow) model_sticky = 1'b1;
         if (i == ph.size() - 1) inst_valid = 1'b0;
         @(posedge clk); #1;
      end
      chk("ready_back", {busy, inst_ready, done}, 3'b010);
   endtask

   initial begin
      #12;
      chk("rst_ready", {inst_ready, busy}, 2'b10);
      chk("rst_en", {enable_fetch, enable_execute, enable_writeback, done, illegal}, 5'b0);
      chk("rst_dec", {write_address, opcode, mux4to1_select, imm_reg_select, ovf_sticky}, '0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      run_inst({1'b0, 6'h20, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0}, 0);               // ADD r3=r1+r2
      run_inst({1'b0, 6'h28, 5'd4, 5'd1, 15'h7FFF}, 0);                      // ADDI r4=r1+0x7FFF
      run_inst({1'b0, 6'h20, 5'd6, 5'd2, 5'd5, 5'd0, 5'b01000}, 0);          // SLLI by 5
      run_inst({1'b0, 6'h22, 5'd7, 20'hABCDE}, 0);                            // MOVI r7
      run_inst({1'b0, 6'h3F, 25'h1234567}, 0);                                // bad opcode
      run_inst({1'b1, 6'h28, 5'd4, 5'd1, 15'h0010}, 0);                       // inst[31] set
      run_inst({1'b0, 6'h2B, 5'd2, 5'd3, 15'h1234}, 1);                       // overflow sets sticky
      chk("sticky_set", ovf_sticky, 1'b1);
      run_inst({1'b0, 6'h2C, 5'd2, 5'd3, 15'h4321}, 2);                       // clear beats set
      chk("sticky_clr", ovf_sticky, 1'b0);

      for (int n = 0; n < 60; n++) begin
         run_inst(rand_inst(), 0);
         if ($urandom_range(0, 3) == 0) begin
            drive_ovf(0);
            if (ovf_clear) model_sticky = 1'b0;
            @(posedge clk); #1;
            chk("idle_gap", {busy, inst_ready, done}, 3'b010);
         end
      end

      // Abort mid-EXEC with sticky set
      run_inst({1'b0, 6'h28, 5'd1, 5'd1, 15'h0001}, 1);
      chk("sticky_pre", ovf_sticky, 1'b1);
      alu_overflow = 1'b0;
      ovf_clear = 1'b0;
      inst = {1'b0, 6'h20, 5'd3, 5'd1, 5'd2, 10'd0};
      inst_valid = 1'b1;
      @(posedge clk); #1;
      inst_valid = 1'b0;
      @(posedge clk); #1;
      chk("in_exec", enable_execute, 1'b1);
      rst = 1'b0;
      #1;
      chk("abort_en", {enable_fetch, enable_execute, enable_writeback, done}, 4'b0);
      chk("abort_rdy", {inst_ready, busy, ovf_sticky}, 3'b100);
      @(posedge clk); #1;
      rst = 1'b1;
      model_sticky = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         chk("post_abort", {enable_fetch, enable_execute, enable_writeback, done, inst_ready}, 5'b00001);
      end
      run_inst({1'b0, 6'h22, 5'd9, 20'h00001}, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/datapath_ctrl.md
# datapath_ctrl

Instruction sequencer for the register-file/ALU datapath. Accepts one 32-bit instruction at a time over a valid/ready handshake, decodes it into register addresses, immediate fields, mux selects and ALU opcodes, and steps the datapath through fetch, execute and writeback with one enable per phase. It also captures ALU overflow into a sticky status and signals completion per instruction.

## Interface
- DataSize, 32, instruction and datapath width
- AddrSize, 5, register address width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- inst  in  DataSize  instruction word; sampled only on acceptance
- inst_valid  in  1  instruction present
- inst_ready  out  1  controller can accept (high only in IDLE)
- alu_overflow  in  1  overflow flag from the ALU
- ovf_clear  in  1  synchronous clear of ovf_sticky
- read_address1, read_address2, write_address  out  AddrSize  register addresses
- enable_fetch, enable_execute, enable_writeback  out  1  phase enables
- imm_5bit / imm_15bit / imm_20bit  out  5 / 15 / 20  immediate fields
- mux4to1_select  out  2  immediate select (00 imm5, 01 imm15 SE, 10 imm15 ZE, 11 imm20)
- imm_reg_select  out  1  1 = ALU src2 from immediate
- mux2to1_select  out  1  1 = write src2 directly (move), 0 = write ALU result
- opcode  out  6; sub_opcode  out  5  to the ALU
- busy  out  1  instruction in flight
- done  out  1  one-cycle pulse at instruction completion
- illegal  out  1  one-cycle pulse with done when the opcode is undecodable
- ovf_sticky  out  1  set by any overflow sampled in WB

## Operation
- Decode fields: opcode=inst[30:25], rt=inst[24:20] → write_address, ra=inst[19:15] → read_address1, rb=inst[14:10] → read_address2, sub=inst[4:0]. inst[31] must be 0; otherwise the instruction is illegal.
- Decode by opcode:
  - 6'b100000 ALU_1: sub_opcode=sub. If sub ∈ {01000 SLLI, 01001 SRLI, 01011 ROTRI}: imm_reg_select=1, mux4to1_select=00, imm_5bit=inst[14:10]. Otherwise: imm_reg_select=0.
  - 6'b101000 ADDI: mux 01, imm_15bit=inst[14:0], imm_reg_select=1, sub_opcode=00000.
  - 6'b101100 ORI and 6'b101011 XORI: mux 10, imm_15bit=inst[14:0], imm_reg_select=1, sub_opcode=00000.
  - 6'b100010 MOVI: mux 11, imm_20bit=inst[19:0], imm_reg_select=1, mux2to1_select=1; the execute phase is skipped.
  - Any other opcode: illegal.
- Outputs the decode drives but the instruction does not use are driven to 0.
- FSM states: IDLE, FETCH, EXEC, WB, FIN.
  - IDLE: inst_ready=1. On inst_valid&&inst_ready, latch inst and all decoded outputs. Go to FETCH if legal; go to FIN with illegal pending if not.
  - FETCH: enable_fetch=1. Go to EXEC, or to WB for MOVI.
  - EXEC: enable_execute=1. Go to WB.
  - WB: enable_writeback=1. If not MOVI, sample alu_overflow and OR it into ovf_sticky. Go to FIN.
  - FIN: done=1, and illegal=1 if pending. Go to IDLE.
- Each enable is high for exactly one cycle per instruction. An illegal instruction asserts no enables.
- Decoded outputs are registered and held stable from the acceptance edge until the next acceptance.
- busy = state≠IDLE.
- ovf_clear has priority over a same-cycle overflow set.

## Timing
- rst low: state IDLE immediately. All outputs 0 except inst_ready=1; ovf_sticky=0.
- rst low mid-instruction: abort with no further enables and no done.
- Latency from the acceptance edge:
  - ALU instruction: FETCH +1 cycle, EXEC +2, WB +3, done +4.
  - MOVI: done at +3.
  - Illegal: done and illegal at +1.
- Throughput: next acceptance earliest in the cycle after done (one cycle in IDLE). Back-to-back ALU instructions therefore start 5 cycles apart.
- inst_valid held high during busy is ignored. inst is not re-sampled until IDLE.

## Test plan
- Reset: with rst=0 mid-EXEC, all enables=0, inst_ready=1, ovf_sticky=0 immediately; no done after release.
- ADD (opcode 100000, sub 00000, rt=3, ra=1, rb=2): enables fetch/exec/wb on cycles +1/+2/+3. Addresses 1/2/3, imm_reg_select=0, done at +4.
- ADDI r4=r1+0x7FFF: mux4to1_select=01, imm_15bit=0x7FFF, imm_reg_select=1. SLLI rb-field 5: mux=00, imm_5bit=5.
- MOVI r7, 0xABCDE: enable_execute never asserted, mux=11, mux2to1_select=1, done at +3.
- Illegal (opcode 111111, and separately inst[31]=1): no enables, done=illegal=1 at +1, inst_ready back at +2.
- Overflow: alu_overflow=1 in WB sets ovf_sticky; ovf_clear and overflow in the same cycle leave ovf_sticky=0. inst_valid held high while busy accepts only one instruction.
